imem_responder: RTL and testbench
=================================

// Module: imem_responder
// PURPOSE
// - Instruction-memory responder: the memory side of the fetch request/response interface.
// - Accepts word fetch requests from the fetch stage.
// - Returns instruction words after a fixed pipeline latency, with in-order responses and response backpressure.
// - A loader write port fills the array before/while pc_rst holds fetch idle.
// - Sits between fetch and the instruction array inside proc_top.
// PARAMETERS
// - DEPTH       1024  instruction words in array (power of 2)
// - LATENCY     2     request-accept to earliest resp_valid, cycles (>=1)
// - FIFO_DEPTH  4     response buffer entries; also max outstanding requests (power of 2, >=2)
// PORTS
// - clk         in   1   clock, all state on rising edge
// - rst         in   1   asynchronous, active-low reset
// - flush       in   1   fetch redirect: drop all in-flight/queued responses
// - req_valid   in   1   fetch request valid
// - req_ready   out  1   responder can accept request
// - req_addr    in   32  byte address of instruction
// - resp_valid  out  1   response valid
// - resp_ready  in   1   fetch consumes response
// - resp_data   out  32  instruction word
// - resp_addr   out  32  echo of req_addr for this response
// - resp_err    out  1   fault flag (see CONFIGURATION)
// - wr_en       in   1   loader write strobe
// - wr_addr     in   32  loader byte address (word-aligned; [1:0] ignored)
// - wr_data     in   32  loader data
// BEHAVIOUR
// - Reset (rst=0, async):
//   - Pipeline valids, FIFO pointers and outstanding counter clear.
//   - req_ready=0 while in reset; 1 on first edge after release.
//   - resp_valid=0; resp_data/resp_addr=0; resp_err=0.
//   - Array contents are NOT reset.
// - Accept: req_valid & req_ready at edge T.
//   - Array read index = req_addr[log2(DEPTH)+1:2].
//   - Read enters LATENCY-stage pipe {valid, data, addr, err}.
// - Pipe exit pushes into a fall-through FIFO.
//   - Empty FIFO: resp_valid asserts in cycle T+LATENCY.
//   - Responses leave strictly in request order.
// - Response handshake:
//   - Pop on resp_valid & resp_ready.
//   - Outputs hold stable while resp_valid & !resp_ready.
// - Credit:
//   - outstanding = in pipe + in FIFO.
//   - req_ready = !flush & (outstanding < FIFO_DEPTH); FIFO can never overflow.
//   - Same-cycle accept and pop: outstanding unchanged.
//   - Full back-to-back throughput of 1 req/cycle while resp_ready=1.
// - Flush (cycle F):
//   - Clears all pipe valids and FIFO at edge F; outstanding=0.
//   - resp_valid=0 from F+1.
//   - req_ready=0 during F; a req_valid in F is not accepted.
//   - A pop in cycle F still completes.
// - Loader write: wr_en writes array at edge.
//   - Read of same word same cycle returns OLD data.
//   - Writes allowed any time; no ordering vs. in-flight reads.
// - Index wraps modulo DEPTH when IMEM_CHECK_EN is off.
// CONFIGURATION
// - IMEM_CHECK_EN defined:
//   - resp_err=1 if req_addr[1:0]!=0 or req_addr>=4*DEPTH.
//   - Faulted response still consumes a slot/credit.
//   - resp_data=32'h0000_0000 (NOP) when resp_err=1.
// - IMEM_CHECK_EN undefined:
//   - resp_err tied 0; addr[1:0] ignored; index wraps modulo DEPTH.
// TESTING
// 1. Load 0x0:0x2408_0005, 0x4:0x2409_0007; req 0x0 at T, resp_ready=1
//    -> resp_valid at T+2, data 0x2408_0005, addr 0x0.
// 2. 8 back-to-back reqs 0x0..0x1C, resp_ready=1
//    -> 8 in-order responses on consecutive cycles, req_ready never drops.
// 3. resp_ready=0, issue reqs until req_ready=0
//    -> exactly 4 accepted; raise resp_ready -> 4 in-order pops, then req_ready=1.
// 4. 3 outstanding, flush + req_valid same cycle
//    -> req not accepted, resp_valid=0 next cycle, no stale response later;
//       new req 0x8 returns word at 0x8.
// 5. IMEM_CHECK_EN: req 0x2 and req 4*DEPTH
//    -> resp_err=1, data 0x0, both ordered.
//    Undefined: req 4*DEPTH -> returns word 0.
// 6. Assert rst with 2 in flight
//    -> resp_valid=0 immediately; after release no response appears; array data retained.

Source files
------------

// File: rtl/imem_responder.sv
// ---------------------------------------------------------------------------
// imem_responder
//   Memory side of the instruction fetch request/response interface.
//   Fetch requests read a word from the instruction array, travel through a
//   LATENCY-deep pipe, and then drain through a small fall-through response
//   FIFO in strict request order. A loader port writes the array at any time.
//
//   Optional feature macro: IMEM_CHECK_EN
//     defined   : misaligned or out-of-range requests return resp_err=1 with
//                 a zero (NOP) data word.
//     undefined : resp_err is held at 0, addr[1:0] is ignored and the word
//                 index wraps modulo DEPTH.
//
// Ports
//   clk         clock, all state on the rising edge
//   rst         asynchronous active-low reset
//   flush       fetch redirect, drops every in-flight and queued response
//   req_valid   fetch request valid
//   req_ready   responder can accept a request
//   req_addr    byte address of the requested instruction
//   resp_valid  response valid
//   resp_ready  fetch consumes the response
//   resp_data   instruction word
//   resp_addr   echo of req_addr for this response
//   resp_err    fault flag (IMEM_CHECK_EN only)
//   wr_en       loader write strobe
//   wr_addr     loader byte address, bits [1:0] ignored
//   wr_data     loader write data
// ---------------------------------------------------------------------------
module imem_responder #(
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [31:0] resp_addr,
  output logic        resp_err,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // -------------------------------------------------------------------------
  // Instruction array (never reset)
  // -------------------------------------------------------------------------
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr[AW+1:2]] <= wr_data;
    end
  end

  // -------------------------------------------------------------------------
  // Request-side read and fault classification
  // -------------------------------------------------------------------------
  logic [AW-1:0] rd_idx;
  logic [31:0]   rd_word;
  logic          rd_err;

  assign rd_idx = req_addr[AW+1:2];

`ifdef IMEM_CHECK_EN
  assign rd_err  = (req_addr[1:0] != 2'b00) || (req_addr >= 32'(4 * DEPTH));
  assign rd_word = rd_err ? 32'h0000_0000 : mem[rd_idx];

  logic unused_bits;
  assign unused_bits = ^{wr_addr[31:AW+2], wr_addr[1:0]};
`else
  assign rd_err  = 1'b0;
  assign rd_word = mem[rd_idx];

  logic unused_bits;
  assign unused_bits = ^{req_addr[31:AW+2], req_addr[1:0],
                         wr_addr[31:AW+2], wr_addr[1:0]};
`endif

  // -------------------------------------------------------------------------
  // Credit tracking
  // -------------------------------------------------------------------------
  // ready_en keeps req_ready low through reset and lets it rise on the first
  // edge after release.
  logic          ready_en;
  logic [CW-1:0] outstanding;
  logic          accept;
  logic          pop;

  assign req_ready = ready_en & ~flush & (outstanding < CW'(FIFO_DEPTH));
  assign accept    = req_valid & req_ready;
  assign pop       = resp_valid & resp_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_en    <= 1'b0;
      outstanding <= '0;
    end else begin
      ready_en <= 1'b1;
      if (flush) begin
        outstanding <= '0;
      end else begin
        outstanding <= outstanding + CW'(accept) - CW'(pop);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read pipe: stage 0 captures the array word at the accept edge, so a
  // loader write to the same word in that cycle is not yet visible.
  // -------------------------------------------------------------------------
  logic [LATENCY-1:0] p_valid;
  logic [31:0]        p_data [LATENCY];
  logic [31:0]        p_addr [LATENCY];
  logic               p_err  [LATENCY];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_valid <= '0;
    end else if (flush) begin
      p_valid <= '0;
    end else begin
      p_valid[0] <= accept;
      for (int i = 1; i < LATENCY; i++) begin
        p_valid[i] <= p_valid[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      p_data[0] <= rd_word;
      p_addr[0] <= req_addr;
      p_err[0]  <= rd_err;
    end
    for (int i = 1; i < LATENCY; i++) begin
      p_data[i] <= p_data[i-1];
      p_addr[i] <= p_addr[i-1];
      p_err[i]  <= p_err[i-1];
    end
  end

  // -------------------------------------------------------------------------
  // Fall-through response FIFO
  // -------------------------------------------------------------------------
  // When the FIFO is empty the pipe exit is presented directly; it is only
  // stored if the consumer does not take it in the same cycle. Credit limits
  // outstanding requests to FIFO_DEPTH, so a push never finds the FIFO full.
  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;
  logic [31:0]  f_data [FIFO_DEPTH];
  logic [31:0]  f_addr [FIFO_DEPTH];
  logic         f_err  [FIFO_DEPTH];
  logic         fifo_empty;
  logic         exit_v;
  logic         fifo_push;
  logic         fifo_pop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign exit_v     = p_valid[LATENCY-1];
  assign fifo_push  = exit_v & ~(fifo_empty & resp_ready);
  assign fifo_pop   = ~fifo_empty & resp_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (fifo_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      f_data[wr_ptr[PW-1:0]] <= p_data[LATENCY-1];
      f_addr[wr_ptr[PW-1:0]] <= p_addr[LATENCY-1];
      f_err[wr_ptr[PW-1:0]]  <= p_err[LATENCY-1];
    end
  end

  // -------------------------------------------------------------------------
  // Response outputs: FIFO head has priority over the pipe exit so order is
  // preserved; outputs read zero whenever nothing is valid.
  // -------------------------------------------------------------------------
  always_comb begin
    resp_valid = 1'b0;
    resp_data  = 32'h0000_0000;
    resp_addr  = 32'h0000_0000;
    resp_err   = 1'b0;
    if (!fifo_empty) begin
      resp_valid = 1'b1;
      resp_data  = f_data[rd_ptr[PW-1:0]];
      resp_addr  = f_addr[rd_ptr[PW-1:0]];
      resp_err   = f_err[rd_ptr[PW-1:0]];
    end else if (exit_v) begin
      resp_valid = 1'b1;
      resp_data  = p_data[LATENCY-1];
      resp_addr  = p_addr[LATENCY-1];
      resp_err   = p_err[LATENCY-1];
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic [31:0] resp_addr;
  logic        resp_err;
  logic        wr_en = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;

  int total = 0;
  int bad = 0;

  logic [31:0] model [16];
  logic [31:0] top_word;

  imem_responder #(.DEPTH(DEPTH), .LATENCY(2), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_addr  (resp_addr),
    .resp_err   (resp_err),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic test_reset;
    tick();
    tick();
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready got=%0b exp=0", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%0b exp=0", resp_valid); end
    total++; if (resp_data !== 32'h0) begin bad++; $display("FAIL reset_resp_data got=%h exp=0", resp_data); end
    total++; if (resp_addr !== 32'h0) begin bad++; $display("FAIL reset_resp_addr got=%h exp=0", resp_addr); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL reset_resp_err got=%0b exp=0", resp_err); end
    rst = 1'b1;
    #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL release_before_edge got=%0b exp=0", req_ready); end
    tick();
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL release_after_edge got=%0b exp=1", req_ready); end
  endtask

  task automatic test_load_single;
    model[0] = 32'h2408_0005;
    model[1] = 32'h2409_0007;
    for (int i = 2; i < 16; i++) model[i] = 32'h1000_0000 + 32'(i * 32'h111);
    top_word = 32'hDEAD_BEEF;
    for (int i = 0; i < 16; i++) load_word(32'(4 * i), model[i]);
    load_word(32'(4 * (DEPTH - 1)), top_word);
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 32'h0;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL single_req_ready got=%0b exp=1", req_ready); end
    tick();
    req_valid = 1'b0;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL single_early got=%0b exp=0", resp_valid); end
    tick();
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b exp=1", resp_valid); end
    total++; if (resp_data !== 32'h2408_0005) begin bad++; $display("FAIL single_data got=%h exp=24080005", resp_data); end
    total++; if (resp_addr !== 32'h0) begin bad++; $display("FAIL single_addr got=%h exp=0", resp_addr); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL single_err got=%0b exp=0", resp_err); end
    tick();
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL single_popped got=%0b exp=0", resp_valid); end
  endtask

  task automatic test_back_to_back;
    logic exp_v;
    resp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        req_valid = 1'b1;
        req_addr  = 32'(4 * c);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready c=%0d got=%0b exp=1", c, req_ready); end
      end else begin
        req_valid = 1'b0;
      end
      exp_v = (c >= 2) && (c < 10);
      total++; if (resp_valid !== exp_v) begin bad++; $display("FAIL b2b_valid c=%0d got=%0b exp=%0b", c, resp_valid, exp_v); end
      if (exp_v) begin
        total++;
        if (resp_data !== model[c-2] || resp_addr !== 32'(4 * (c - 2))) begin
          bad++;
          $display("FAIL b2b_resp c=%0d got=%h/%h exp=%h/%h", c, resp_data, resp_addr, model[c-2], 32'(4 * (c - 2)));
        end
      end
      tick();
    end
    req_valid = 1'b0;
  endtask

  task automatic test_backpressure;
    int acc;
    acc = 0;
    resp_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      req_valid = 1'b1;
      req_addr  = 32'h20 + 32'(4 * acc);
      #1;
      if (req_ready !== 1'b1) break;
      tick();
      acc++;
    end
    req_valid = 1'b0;
    total++; if (acc !== 4) begin bad++; $display("FAIL bp_accepted got=%0d exp=4", acc); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_low got=%0b exp=0", req_ready); end
    tick();
    tick();
    total++; if (resp_valid !== 1'b1 || resp_data !== model[8] || resp_addr !== 32'h20) begin
      bad++; $display("FAIL bp_stall_hold got=%0b/%h/%h exp=1/%h/00000020", resp_valid, resp_data, resp_addr, model[8]);
    end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_still_low got=%0b exp=0", req_ready); end
    resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (resp_valid !== 1'b1 || resp_data !== model[8+k] || resp_addr !== 32'h20 + 32'(4 * k)) begin
        bad++; $display("FAIL bp_drain k=%0d got=%0b/%h/%h exp=1/%h/%h", k, resp_valid, resp_data, resp_addr, model[8+k], 32'h20 + 32'(4 * k));
      end
      tick();
    end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%0b exp=0", resp_valid); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%0b exp=1", req_ready); end
  endtask

  task automatic test_flush;
    resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1;
      req_addr  = 32'h30 + 32'(4 * k);
      tick();
    end
    flush     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h3C;
    #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%0b exp=0", req_ready); end
    total++; if (resp_valid !== 1'b1 || resp_data !== model[12]) begin
      bad++; $display("FAIL flush_pre_valid got=%0b/%h exp=1/%h", resp_valid, resp_data, model[12]);
    end
    tick();
    flush     = 1'b0;
    req_valid = 1'b0;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL flush_next got=%0b exp=0", resp_valid); end
    resp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL flush_stale k=%0d got=%0b data=%h exp=0", k, resp_valid, resp_data); end
      tick();
    end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL flush_ready_back got=%0b exp=1", req_ready); end
    req_valid = 1'b1;
    req_addr  = 32'h8;
    tick();
    req_valid = 1'b0;
    tick();
    total++; if (resp_valid !== 1'b1 || resp_data !== model[2] || resp_addr !== 32'h8) begin
      bad++; $display("FAIL flush_new got=%0b/%h/%h exp=1/%h/00000008", resp_valid, resp_data, resp_addr, model[2]);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL flush_after k=%0d got=%0b exp=0", k, resp_valid); end
      tick();
    end
  endtask

  task automatic test_addr_range;
    logic [31:0] a_tab [3];
    logic [31:0] d_tab [3];
    logic        e_tab [3];
    a_tab[0] = 32'h2;
    a_tab[1] = 32'(4 * DEPTH);
    a_tab[2] = 32'(4 * (DEPTH - 1));
`ifdef IMEM_CHECK_EN
    d_tab[0] = 32'h0;      e_tab[0] = 1'b1;
    d_tab[1] = 32'h0;      e_tab[1] = 1'b1;
`else
    d_tab[0] = model[0];   e_tab[0] = 1'b0;
    d_tab[1] = model[0];   e_tab[1] = 1'b0;
`endif
    d_tab[2] = top_word;   e_tab[2] = 1'b0;
    resp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c < 3) begin
        req_valid = 1'b1;
        req_addr  = a_tab[c];
      end else begin
        req_valid = 1'b0;
      end
      if (c >= 2 && c < 5) begin
        total++;
        if (resp_valid !== 1'b1 || resp_data !== d_tab[c-2] || resp_addr !== a_tab[c-2] || resp_err !== e_tab[c-2]) begin
          bad++; $display("FAIL range c=%0d got=%0b/%h/%h/%0b exp=1/%h/%h/%0b", c, resp_valid, resp_data, resp_addr, resp_err, d_tab[c-2], a_tab[c-2], e_tab[c-2]);
        end
      end else begin
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL range_idle c=%0d got=%0b exp=0", c, resp_valid); end
      end
      tick();
    end
  endtask

  task automatic test_write_collision;
    logic [31:0] old_word;
    old_word   = model[4];
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 32'h10;
    wr_en      = 1'b1;
    wr_addr    = 32'h13;
    wr_data    = 32'hCAFE_0004;
    tick();
    wr_en    = 1'b0;
    model[4] = 32'hCAFE_0004;
    tick();
    req_valid = 1'b0;
    total++; if (resp_valid !== 1'b1 || resp_data !== old_word) begin
      bad++; $display("FAIL wr_same_cycle got=%0b/%h exp=1/%h", resp_valid, resp_data, old_word);
    end
    tick();
    total++; if (resp_valid !== 1'b1 || resp_data !== 32'hCAFE_0004) begin
      bad++; $display("FAIL wr_after got=%0b/%h exp=1/cafe0004", resp_valid, resp_data);
    end
    tick();
  endtask

  task automatic test_reset_inflight;
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 32'h14;
    tick();
    req_addr   = 32'h18;
    tick();
    req_valid  = 1'b0;
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL rstf_pre got=%0b exp=1", resp_valid); end
    rst = 1'b0;
    #1;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rstf_valid got=%0b exp=0", resp_valid); end
    total++; if (resp_data !== 32'h0) begin bad++; $display("FAIL rstf_data got=%h exp=0", resp_data); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rstf_ready got=%0b exp=0", req_ready); end
    tick();
    tick();
    rst = 1'b1;
    tick();
    resp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rstf_stale k=%0d got=%0b exp=0", k, resp_valid); end
      tick();
    end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rstf_ready_back got=%0b exp=1", req_ready); end
    req_valid = 1'b1;
    req_addr  = 32'h14;
    tick();
    req_addr  = 32'(4 * (DEPTH - 1));
    tick();
    req_valid = 1'b0;
    total++; if (resp_valid !== 1'b1 || resp_data !== model[5]) begin
      bad++; $display("FAIL rstf_retain5 got=%0b/%h exp=1/%h", resp_valid, resp_data, model[5]);
    end
    tick();
    total++; if (resp_valid !== 1'b1 || resp_data !== top_word) begin
      bad++; $display("FAIL rstf_retain_top got=%0b/%h exp=1/%h", resp_valid, resp_data, top_word);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_load_single();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_addr_range();
    test_write_collision();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
